// File: rtl/fifo_enq_arbiter_pkg.sv
// Shared sizing helpers for the fifo_enq_arbiter family: effective depth,
// occupancy counter width and round-robin pointer width.
package fifo_enq_arbiter_pkg;

    // Depths below 2 are promoted to 2 so full/empty never coincide.
    function automatic int unsigned true_depth(input int unsigned depth);
        return (depth < 2) ? 2 : depth;
    endfunction

    function automatic int unsigned cntr_width(input int unsigned depth);
        return $clog2(true_depth(depth) + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/fifo_enq_arbiter_if.sv
// Enqueue-request / occupancy bundle between requesters, consumer and the
// arbiter. LOCK exists only when ARB_LOCK_EN is defined.
interface fifo_enq_arbiter_if #(
    parameter int unsigned p1nreq       = 4,
    parameter int unsigned p3cntr_width = 3
);
    logic [p1nreq-1:0]       REQ;
`ifdef ARB_LOCK_EN
    logic [p1nreq-1:0]       LOCK;
`endif
    logic [p1nreq-1:0]       GRANT;
    logic                    DEQ;
    logic                    EMPTY_N;
    logic                    FULL_N;
    logic [p3cntr_width-1:0] COUNT;
    logic                    ERR;

    modport master (
        output REQ,
`ifdef ARB_LOCK_EN
        output LOCK,
`endif
        output DEQ,
        input  GRANT, EMPTY_N, FULL_N, COUNT, ERR
    );

    modport slave (
        input  REQ,
`ifdef ARB_LOCK_EN
        input  LOCK,
`endif
        input  DEQ,
        output GRANT, EMPTY_N, FULL_N, COUNT, ERR
    );
endinterface

// File: rtl/fifo_enq_arbiter_rr_arb_core.sv
// Round-robin selector: first requesting index at or after ptr, wrapping
// from nreq-1 to 0. Purely combinational.
module rr_arb_core #(
    parameter int unsigned p1nreq    = 4,
    parameter int unsigned ptr_width = 2
) (
    input  logic [p1nreq-1:0]    req,
    input  logic [ptr_width-1:0] ptr,
    output logic [p1nreq-1:0]    grant,
    output logic [ptr_width-1:0] grant_idx,
    output logic                 grant_vld
);
    logic [ptr_width-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < p1nreq; i++) begin
            idx = ptr_width'((32'(ptr) + i) % p1nreq);
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin enqueue arbiter in front of a shared FIFO, with occupancy
// tracking and sticky error flag. Optional burst lock: ARB_LOCK_EN.
module fifo_enq_arbiter
    import fifo_enq_arbiter_pkg::*;
#(
    parameter int unsigned p1nreq       = 4,
    parameter int unsigned p2depth      = 4,
    parameter int unsigned p3cntr_width = cntr_width(p2depth)
) (
    input logic               CLK,
    input logic               RST,
    input logic               CLR,
    fifo_enq_arbiter_if.slave arb
);
    localparam int unsigned PW = ptr_width(p1nreq);
    localparam logic [p3cntr_width-1:0] DEPTH_C = p3cntr_width'(true_depth(p2depth));
    localparam logic [PW-1:0] LAST_IDX = PW'(p1nreq - 1);

    logic [p3cntr_width-1:0] count_q, count_nxt;
    logic                    not_empty_q;
    logic                    not_full_q;
    logic                    err_q;
    logic [PW-1:0]           ptr_q;

    logic [p1nreq-1:0] arb_grant;
    logic [PW-1:0]     arb_idx;
    logic              arb_vld;
    logic [p1nreq-1:0] grant;
    logic [PW-1:0]     sel_idx;
    logic              full_n;
    logic              grant_ok;
    logic              enq;
    logic              deq_vld;

    rr_arb_core #(
        .p1nreq    (p1nreq),
        .ptr_width (PW)
    ) u_rr_arb_core (
        .req       (arb.REQ),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

`ifdef ARB_LOCK_EN
    logic          owner_vld;
    logic [PW-1:0] owner_idx;
    logic          owner_hold;

    assign owner_hold = owner_vld && arb.REQ[owner_idx] && arb.LOCK[owner_idx];
`endif

    assign full_n   = not_full_q | arb.DEQ;
    assign grant_ok = !RST && !CLR && full_n;

    always_comb begin
        grant   = '0;
        sel_idx = arb_idx;
        if (grant_ok) begin
`ifdef ARB_LOCK_EN
            if (owner_hold) begin
                grant[owner_idx] = 1'b1;
                sel_idx          = owner_idx;
            end else
`endif
            if (arb_vld) begin
                grant   = arb_grant;
                sel_idx = arb_idx;
            end
        end
    end

    assign enq     = |grant;
    assign deq_vld = arb.DEQ && not_empty_q;

    always_comb begin
        count_nxt = count_q;
        if (enq && !deq_vld)
            count_nxt = count_q + p3cntr_width'(1);
        else if (deq_vld && !enq)
            count_nxt = count_q - p3cntr_width'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            count_q     <= '0;
            not_empty_q <= 1'b0;
            not_full_q  <= 1'b1;
            ptr_q       <= '0;
            if (RST)
                err_q <= 1'b0;
        end else begin
            count_q     <= count_nxt;
            not_empty_q <= (count_nxt != '0);
            not_full_q  <= (count_nxt != DEPTH_C);
            if (enq)
                ptr_q <= (sel_idx == LAST_IDX) ? '0 : sel_idx + PW'(1);
            if (arb.DEQ && !not_empty_q)
                err_q <= 1'b1;
        end
    end

`ifdef ARB_LOCK_EN
    // Ownership is taken by any grant made with LOCK set; it lapses once the
    // owner drops REQ or LOCK, and ptr has already moved past it by then.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            owner_vld <= 1'b0;
            owner_idx <= '0;
        end else if (enq) begin
            owner_vld <= arb.LOCK[sel_idx];
            owner_idx <= sel_idx;
        end else if (!owner_hold) begin
            owner_vld <= 1'b0;
        end
    end
`endif

    assign arb.GRANT   = grant;
    assign arb.EMPTY_N = not_empty_q;
    assign arb.FULL_N  = full_n;
    assign arb.COUNT   = count_q;
    assign arb.ERR     = err_q;
endmodule

// File: doc/fifo_enq_arbiter.md
FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

Interface
REQ-001 SHALL have parameter p1nreq, default 4, number of enqueue requesters (2..8).
REQ-002 SHALL have parameter p2depth, default 4, shared FIFO depth (values below 2 treated as 2).
REQ-003 SHALL have parameter p3cntr_width, default 3, occupancy counter width, equal to log2(p2depth+1).
REQ-004 SHALL have port CLK, input, 1, sole clock; all state on posedge CLK.
REQ-005 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port CLR, input, 1, synchronous clear of occupancy and arbitration state.
REQ-007 SHALL have port REQ, input, p1nreq, per-requester enqueue request.
REQ-008 SHALL have port LOCK, input, p1nreq, per-requester burst hold; only present when ARB_LOCK_EN is defined.
REQ-009 SHALL have port GRANT, output, p1nreq, one-hot-or-zero enqueue grant, combinational.
REQ-010 SHALL have port DEQ, input, 1, consumer dequeue.
REQ-011 SHALL have port EMPTY_N, output, 1, occupancy nonzero.
REQ-012 SHALL have port FULL_N, output, 1, space available: not_full OR DEQ (loopy).
REQ-013 SHALL have port COUNT, output, p3cntr_width, current occupancy.
REQ-014 SHALL have port ERR, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL assert at most one GRANT bit per cycle, and only where REQ is set.
REQ-016 SHALL assert a grant only when FULL_N=1 (same-cycle DEQ frees a slot when full).
REQ-017 SHALL grant the first requesting index at or after the priority pointer ptr, wrapping p1nreq-1 to 0.
REQ-018 SHALL set ptr to (granted index+1) mod p1nreq on each granted cycle; otherwise ptr holds.
REQ-019 SHALL treat enq as |GRANT.
REQ-020 SHALL increment COUNT on enq without a valid deq.
REQ-021 SHALL decrement COUNT on a valid deq without enq.
REQ-022 SHALL hold COUNT when enq and a valid deq occur together.
REQ-023 SHALL define a valid deq as DEQ=1 while EMPTY_N=1.
REQ-024 SHALL register not_full=0 exactly when COUNT becomes p2depth.
REQ-025 SHALL register not_empty=0 exactly when COUNT becomes 0.
REQ-026 SHALL ignore DEQ while EMPTY_N=0 (no count change) and set ERR.
REQ-027 SHALL never allow COUNT to wrap above p2depth or below 0.
REQ-028 SHALL give CLR priority over enq/deq: COUNT=0, EMPTY_N=0, not_full=1, ptr=0; ERR unchanged.
REQ-029 SHALL suppress GRANT while CLR=1.

Reset
REQ-030 SHALL, while RST=1 at posedge CLK, set COUNT=0, not_empty=0, not_full=1, ptr=0, ERR=0, lock state cleared.
REQ-031 SHALL force GRANT=0 while RST=1.
REQ-032 SHALL, on RST asserted mid-operation, discard in-flight occupancy; the first post-reset grant goes to the lowest requesting index.

Configuration
REQ-033 SHALL, with ARB_LOCK_EN defined, keep a granted requester as owner while its REQ and LOCK stay 1; no other index is granted meanwhile; ptr advances on owner release.
REQ-034 SHALL, with ARB_LOCK_EN undefined, omit the LOCK port and lock state and behave as pure round-robin.

Structure
REQ-035 SHALL place the truedepth rule (max(p2depth,2)) and the counter-width relation in the shared FIFO package/include used by the sized FIFO family.
REQ-036 SHALL implement round-robin selection in one sub-module, rr_arb_core (REQ, ptr -> one-hot grant); occupancy tracking stays in the top level.

Verification
REQ-037 SHALL cover round-robin fairness: p1nreq=4, REQ=4'b1111 for 4 cycles, no DEQ -> GRANT 0001,0010,0100,1000; COUNT 1..4; FULL_N=0.
REQ-038 SHALL cover loopy full: COUNT=4, REQ=0001, DEQ=1 -> GRANT=0001 that cycle; COUNT stays 4; EMPTY_N=1.
REQ-039 SHALL cover empty dequeue: reset, DEQ=1, REQ=0 -> COUNT=0, EMPTY_N=0, ERR=1 next cycle and held.
REQ-040 SHALL cover CLR vs enq: COUNT=3, CLR=1 with REQ=0010 -> GRANT=0; next cycle COUNT=0, EMPTY_N=0, FULL_N=1, ptr=0.
REQ-041 SHALL cover lock (ARB_LOCK_EN): REQ=1111, LOCK=0100 held 3 cycles after idx2 granted -> GRANT=0100 for all 3; then LOCK=0 -> GRANT=1000.
REQ-042 SHALL cover mid-operation reset: COUNT=2, ptr=3, RST=1 one cycle -> COUNT=0, ERR=0; REQ=1010 then -> GRANT=0010.
